// File: rtl/srl_updown_cnt.sv
// rtl/srl_updown_cnt.sv - clock-enabled SRL delay line plus loadable up/down counter.
// Optional triplicated counter with majority vote on output and feedback.
module srl_updown_cnt #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 2,
    parameter int TMR   = 0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             SRL_CE,
    input  logic             SRL_I,
    output logic             SRL_O,
    input  logic             CNT_CE,
    input  logic             CNT_L,
    input  logic             CNT_UP,
    input  logic [WIDTH-1:0] CNT_D,
    output logic [WIDTH-1:0] CNT_Q
);

    // Delay line: no reset so it maps onto SRL primitives; power-up contents are zero.
    logic [DEPTH-1:0] srl_q = '0;
    logic [DEPTH-1:0] srl_d;
    logic [DEPTH:0]   srl_shifted;

    always_comb begin
        srl_shifted = {srl_q, SRL_I};
        srl_d       = srl_q;
        if (SRL_CE) begin
            srl_d = srl_shifted[DEPTH-1:0];
        end
    end

    always_ff @(posedge CLK) begin
        srl_q <= srl_d;
    end

    assign SRL_O = srl_q[DEPTH-1];

    logic [WIDTH-1:0] cnt_vote;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_vote;
        if (CNT_L) begin
            cnt_d = CNT_D;
        end else if (CNT_CE) begin
            if (CNT_UP) begin
                cnt_d = cnt_vote + WIDTH'(1);
            end else begin
                cnt_d = cnt_vote - WIDTH'(1);
            end
        end
    end

    generate
        if (TMR != 0) begin : g_tmr
            // Each copy reloads from the voted value so a single upset is scrubbed next edge.
            (* keep = "true", dont_touch = "true" *) logic [WIDTH-1:0] cnt_a_q;
            (* keep = "true", dont_touch = "true" *) logic [WIDTH-1:0] cnt_b_q;
            (* keep = "true", dont_touch = "true" *) logic [WIDTH-1:0] cnt_c_q;

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    cnt_a_q <= '0;
                end else begin
                    cnt_a_q <= cnt_d;
                end
            end

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    cnt_b_q <= '0;
                end else begin
                    cnt_b_q <= cnt_d;
                end
            end

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    cnt_c_q <= '0;
                end else begin
                    cnt_c_q <= cnt_d;
                end
            end

            assign cnt_vote = (cnt_a_q & cnt_b_q) | (cnt_a_q & cnt_c_q) | (cnt_b_q & cnt_c_q);
        end else begin : g_single
            logic [WIDTH-1:0] cnt_q;

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign cnt_vote = cnt_q;
        end
    endgenerate

    assign CNT_Q = cnt_vote;

endmodule

// File: tb/tb_srl_updown_cnt.sv
// tb/tb_srl_updown_cnt.sv - directed self-checking bench for srl_updown_cnt.
module tb_srl_updown_cnt;

    logic       clk = 1'b0;
    logic       rst;
    logic       srl_ce;
    logic       srl_i;
    logic       cnt_ce;
    logic       cnt_l;
    logic       cnt_up;
    logic [1:0] cnt_d;

    logic       srl_o_16, srl_o_16t, srl_o_1, srl_o_368;
    logic [1:0] cnt_q_16, cnt_q_16t, cnt_q_1, cnt_q_368;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    srl_updown_cnt #(.DEPTH(16), .WIDTH(2), .TMR(0)) u_d16 (
        .CLK(clk), .RST(rst), .SRL_CE(srl_ce), .SRL_I(srl_i), .SRL_O(srl_o_16),
        .CNT_CE(cnt_ce), .CNT_L(cnt_l), .CNT_UP(cnt_up), .CNT_D(cnt_d), .CNT_Q(cnt_q_16)
    );

    srl_updown_cnt #(.DEPTH(16), .WIDTH(2), .TMR(1)) u_d16_tmr (
        .CLK(clk), .RST(rst), .SRL_CE(srl_ce), .SRL_I(srl_i), .SRL_O(srl_o_16t),
        .CNT_CE(cnt_ce), .CNT_L(cnt_l), .CNT_UP(cnt_up), .CNT_D(cnt_d), .CNT_Q(cnt_q_16t)
    );

    srl_updown_cnt #(.DEPTH(1), .WIDTH(2), .TMR(0)) u_d1 (
        .CLK(clk), .RST(rst), .SRL_CE(srl_ce), .SRL_I(srl_i), .SRL_O(srl_o_1),
        .CNT_CE(cnt_ce), .CNT_L(cnt_l), .CNT_UP(cnt_up), .CNT_D(cnt_d), .CNT_Q(cnt_q_1)
    );

    srl_updown_cnt #(.DEPTH(368), .WIDTH(2), .TMR(0)) u_d368 (
        .CLK(clk), .RST(rst), .SRL_CE(srl_ce), .SRL_I(srl_i), .SRL_O(srl_o_368),
        .CNT_CE(cnt_ce), .CNT_L(cnt_l), .CNT_UP(cnt_up), .CNT_D(cnt_d), .CNT_Q(cnt_q_368)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int up_seq[5] = '{1, 2, 3, 0, 1};
    int dn_seq[2] = '{0, 3};
    int first_16, first_1, first_368, hi_16, hi_1, hi_368;
    int win_exp;
    logic p;

    initial begin
        rst    = 1'b1;
        srl_ce = 1'b0;
        srl_i  = 1'b0;
        cnt_ce = 1'b0;
        cnt_l  = 1'b0;
        cnt_up = 1'b0;
        cnt_d  = 2'd0;
        #2;
        check("reset_cnt", cnt_q_16, 0);
        check("reset_cnt_tmr", cnt_q_16t, 0);
        check("powerup_srl16", srl_o_16, 0);
        check("powerup_srl1", srl_o_1, 0);
        check("powerup_srl368", srl_o_368, 0);

        // Counter: count up through wrap, then down through wrap.
        rst    = 1'b0;
        cnt_ce = 1'b1;
        cnt_up = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("up%0d", i), cnt_q_16, up_seq[i]);
            check($sformatf("up%0d_tmr", i), cnt_q_16t, up_seq[i]);
        end
        cnt_up = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            check($sformatf("dn%0d", i), cnt_q_16, dn_seq[i]);
            check($sformatf("dn%0d_tmr", i), cnt_q_16t, dn_seq[i]);
        end

        cnt_l  = 1'b1;
        cnt_d  = 2'd2;
        cnt_up = 1'b1;
        step();
        check("load_wins", cnt_q_16, 2);
        check("load_wins_tmr", cnt_q_16t, 2);

        cnt_l  = 1'b0;
        cnt_ce = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("async_rst", cnt_q_16, 0);
        check("async_rst_tmr", cnt_q_16t, 0);
        rst    = 1'b0;
        cnt_ce = 1'b1;
        cnt_up = 1'b0;
        step();
        check("post_rst_dec", cnt_q_16, 3);
        check("post_rst_dec_tmr", cnt_q_16t, 3);
        cnt_ce = 1'b0;

        // Delay latency for DEPTH 1/16/368 with a reset pulse while in flight.
        srl_ce    = 1'b1;
        srl_i     = 1'b1;
        first_16  = 0; first_1 = 0; first_368 = 0;
        hi_16     = 0; hi_1 = 0; hi_368 = 0;
        for (int e = 1; e <= 370; e++) begin
            step();
            srl_i = 1'b0;
            rst   = (e == 8);
            if (srl_o_16)  begin hi_16++;  if (first_16 == 0)  first_16 = e;  end
            if (srl_o_1)   begin hi_1++;   if (first_1 == 0)   first_1 = e;   end
            if (srl_o_368) begin hi_368++; if (first_368 == 0) first_368 = e; end
        end
        rst = 1'b0;
        check("lat16", first_16, 16);
        check("width16", hi_16, 1);
        check("lat1", first_1, 1);
        check("width1", hi_1, 1);
        check("lat368", first_368, 368);
        check("width368", hi_368, 1);

        // Four held edges while the pulse is in flight delay it by four.
        srl_i    = 1'b1;
        first_16 = 0;
        hi_16    = 0;
        for (int e = 1; e <= 30; e++) begin
            step();
            srl_i  = 1'b0;
            srl_ce = !(e >= 5 && e <= 8);
            if (srl_o_16) begin hi_16++; if (first_16 == 0) first_16 = e; end
        end
        srl_ce = 1'b1;
        check("hold_lat16", first_16, 20);
        check("hold_width16", hi_16, 1);

        // Window counting: pulses at cycles 0, 3, 16.
        rst = 1'b1;
        #1;
        rst = 1'b0;
        for (int c = 0; c <= 34; c++) begin
            p      = (c == 0) || (c == 3) || (c == 16);
            srl_i  = p;
            cnt_up = p;
            cnt_ce = p ^ srl_o_16;
            step();
            win_exp = 0;
            if (c >= 0  && c < 16) win_exp++;
            if (c >= 3  && c < 19) win_exp++;
            if (c >= 16 && c < 32) win_exp++;
            check($sformatf("win_c%0d", c), cnt_q_16, win_exp);
            check($sformatf("win_c%0d_tmr", c), cnt_q_16t, win_exp);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
